// File: rtl/cc1200_pkg.sv
// Shared types and constants for the CC1200 receive framer.
// Contents: framing state enum, signed-score width helper, default sync words.
package cc1200_pkg;

    // Framing states: hunting for sync, capturing header address, unpacking samples.
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ADDR    = 2'd1,
        PAYLOAD = 2'd2
    } frm_state_e;

    // Default frame (index 0) and line (index 1) sync patterns.
    localparam logic [31:0] FRAME_SYNC_DEFAULT = 32'h930B51DE;
    localparam logic [31:0] LINE_SYNC_DEFAULT  = 32'h6CF4AE21;

    // Width of a signed score spanning -sync_w..+sync_w.
    function automatic int unsigned sc_width(input int unsigned sync_w);
        return $clog2(sync_w + 1) + 1;
    endfunction

endpackage

// File: rtl/cc1200_sync_corr.sv
// Sliding-window correlator for the CC1200 framer.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   bit_valid, bit_in new received bit strobe and value
//   fill_clr          restart the fill count (entry to HUNT)
//   sync_words        N_SYNC packed sync patterns
//   cor_thre          signed match threshold
//   match_c           a word matched on the current bit (combinational)
//   match_id_c        lowest matching word index (combinational)
//   match_score_c     score of that word (combinational)
module cc1200_sync_corr
    import cc1200_pkg::*;
#(
    parameter int unsigned SYNC_W = 32,
    parameter int unsigned N_SYNC = 2,
    parameter int unsigned SC_W   = sc_width(SYNC_W),
    parameter int unsigned ID_W   = (N_SYNC > 1) ? $clog2(N_SYNC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    input  logic                     fill_clr,
    input  logic [N_SYNC*SYNC_W-1:0] sync_words,
    input  logic [SC_W-1:0]          cor_thre,
    output logic                     match_c,
    output logic [ID_W-1:0]          match_id_c,
    output logic [SC_W-1:0]          match_score_c
);

    localparam int unsigned FILL_W = $clog2(SYNC_W + 1);

    // Only the older SYNC_W-1 bits are stored; the current bit completes the window.
    logic [SYNC_W-2:0] win_q, win_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [SYNC_W-1:0] win_next;
    logic [SC_W-1:0]   score_k;
    logic              full;

    // Window shift and saturating fill counter.
    always_comb begin
        win_next = {win_q, bit_in};
        win_d    = win_q;
        fill_d   = fill_q;
        if (bit_valid) begin
            win_d = win_next[SYNC_W-2:0];
        end
        if (fill_clr) begin
            fill_d = '0;
        end else if (bit_valid && (fill_q != FILL_W'(SYNC_W))) begin
            fill_d = fill_q + FILL_W'(1);
        end
    end

    // Per-word scores and lowest-index priority select.
    always_comb begin
        full          = (fill_q >= FILL_W'(SYNC_W - 1));
        match_c       = 1'b0;
        match_id_c    = '0;
        match_score_c = '0;
        score_k       = '0;
        for (int k = 0; k < N_SYNC; k++) begin
            score_k = SC_W'(SYNC_W) -
                      SC_W'(2 * $countones(win_next ^ sync_words[k*SYNC_W +: SYNC_W]));
            if (!match_c && bit_valid && full && ($signed(score_k) > $signed(cor_thre))) begin
                match_c       = 1'b1;
                match_id_c    = ID_W'(k);
                match_score_c = score_k;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win_q  <= '0;
            fill_q <= '0;
        end else begin
            win_q  <= win_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/cc1200_sync_framer.sv
// Receive-side bit-stream framer: sync correlation, header address capture,
// payload sample unpacking.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   bit_valid, bit_in received bit strobe and value (MSB-first)
//   sync_words        N_SYNC sync patterns, word k at [k*SYNC_W +: SYNC_W]
//   cor_thre          signed match threshold
//   pkt_len           samples per packet (0 = header only)
//   abort             force return to HUNT
//   sync_hit/_id/_score  match pulse, matched index, matched score
//   addr, addr_valid     captured header address and pulse
//   sample, sample_valid unpacked sample and pulse
//   pkt_done          pulse after the last sample (or address when pkt_len is 0)
//   busy              high in ADDR or PAYLOAD
module cc1200_sync_framer
    import cc1200_pkg::*;
#(
    parameter int unsigned SYNC_W   = 32,
    parameter int unsigned N_SYNC   = 2,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned SAMPLE_W = 12,
    parameter int unsigned LEN_W    = 10
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          bit_valid,
    input  logic                                          bit_in,
    input  logic [N_SYNC*SYNC_W-1:0]                      sync_words,
    input  logic [$clog2(SYNC_W+1):0]                     cor_thre,
    input  logic [LEN_W-1:0]                              pkt_len,
    input  logic                                          abort,
    output logic                                          sync_hit,
    output logic [((N_SYNC > 1) ? $clog2(N_SYNC) : 1)-1:0] sync_id,
    output logic [$clog2(SYNC_W+1):0]                     sync_score,
    output logic [ADDR_W-1:0]                             addr,
    output logic                                          addr_valid,
    output logic [SAMPLE_W-1:0]                           sample,
    output logic                                          sample_valid,
    output logic                                          pkt_done,
    output logic                                          busy
);

    localparam int unsigned SC_W  = sc_width(SYNC_W);
    localparam int unsigned ID_W  = (N_SYNC > 1) ? $clog2(N_SYNC) : 1;
    localparam int unsigned SH_W  = (ADDR_W > SAMPLE_W) ? ADDR_W : SAMPLE_W;
    localparam int unsigned CNT_W = $clog2(SH_W + 1);

    frm_state_e state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]    smp_cnt_q, smp_cnt_d;
    // Holds the bits preceding the current one; the current bit completes a field.
    logic [SH_W-2:0]     sh_q, sh_d;
    logic                sync_hit_q, sync_hit_d;
    logic [ID_W-1:0]     sync_id_q, sync_id_d;
    logic [SC_W-1:0]     sync_score_q, sync_score_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                addr_valid_q, addr_valid_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;
    logic                sample_valid_q, sample_valid_d;
    logic                pkt_done_q, pkt_done_d;
    logic                busy_q, busy_d;

    logic                match_c;
    logic [ID_W-1:0]     match_id_c;
    logic [SC_W-1:0]     match_score_c;
    logic                fill_clr;

    // Fill restarts on every transition back into HUNT, so a new match needs
    // a full window of post-packet bits.
    assign fill_clr = (state_q != HUNT) && (state_d == HUNT);

    cc1200_sync_corr #(
        .SYNC_W (SYNC_W),
        .N_SYNC (N_SYNC),
        .SC_W   (SC_W),
        .ID_W   (ID_W)
    ) u_corr (
        .clk           (clk),
        .rst           (rst),
        .bit_valid     (bit_valid),
        .bit_in        (bit_in),
        .fill_clr      (fill_clr),
        .sync_words    (sync_words),
        .cor_thre      (cor_thre),
        .match_c       (match_c),
        .match_id_c    (match_id_c),
        .match_score_c (match_score_c)
    );

    // Framing next-state and output logic.
    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        smp_cnt_d      = smp_cnt_q;
        sh_d           = sh_q;
        sync_hit_d     = 1'b0;
        sync_id_d      = sync_id_q;
        sync_score_d   = sync_score_q;
        addr_d         = addr_q;
        addr_valid_d   = 1'b0;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        pkt_done_d     = 1'b0;

        if (abort) begin
            // Abort beats any match or field completion in the same cycle.
            state_d   = HUNT;
            bit_cnt_d = '0;
            smp_cnt_d = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (match_c) begin
                        state_d      = ADDR;
                        sync_hit_d   = 1'b1;
                        sync_id_d    = match_id_c;
                        sync_score_d = match_score_c;
                        bit_cnt_d    = '0;
                        smp_cnt_d    = '0;
                    end
                end
                ADDR: begin
                    if (bit_valid) begin
                        sh_d = {sh_q[SH_W-3:0], bit_in};
                        if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                            addr_d       = {sh_q[ADDR_W-2:0], bit_in};
                            addr_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                            if (pkt_len == '0) begin
                                pkt_done_d = 1'b1;
                                state_d    = HUNT;
                            end else begin
                                state_d = PAYLOAD;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (bit_valid) begin
                        sh_d = {sh_q[SH_W-3:0], bit_in};
                        if (bit_cnt_q == CNT_W'(SAMPLE_W - 1)) begin
                            sample_d       = {sh_q[SAMPLE_W-2:0], bit_in};
                            sample_valid_d = 1'b1;
                            bit_cnt_d      = '0;
                            smp_cnt_d      = smp_cnt_q + LEN_W'(1);
                            if (smp_cnt_d == pkt_len) begin
                                pkt_done_d = 1'b1;
                                state_d    = HUNT;
                                smp_cnt_d  = '0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end

        busy_d = (state_d != HUNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= HUNT;
            bit_cnt_q      <= '0;
            smp_cnt_q      <= '0;
            sh_q           <= '0;
            sync_hit_q     <= 1'b0;
            sync_id_q      <= '0;
            sync_score_q   <= '0;
            addr_q         <= '0;
            addr_valid_q   <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            pkt_done_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            smp_cnt_q      <= smp_cnt_d;
            sh_q           <= sh_d;
            sync_hit_q     <= sync_hit_d;
            sync_id_q      <= sync_id_d;
            sync_score_q   <= sync_score_d;
            addr_q         <= addr_d;
            addr_valid_q   <= addr_valid_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            pkt_done_q     <= pkt_done_d;
            busy_q         <= busy_d;
        end
    end

    assign sync_hit     = sync_hit_q;
    assign sync_id      = sync_id_q;
    assign sync_score   = sync_score_q;
    assign addr         = addr_q;
    assign addr_valid   = addr_valid_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign pkt_done     = pkt_done_q;
    assign busy         = busy_q;

endmodule
